fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side master for the team's synchronous FIFO: drives the FIFO pop interface (rd_en / rdata / empty / rd_error) and hands the popped words to a downstream valid/ready stream.
- On a start request it pops exactly len_i words, absorbs the FIFO's 1-cycle registered read latency with a 2-entry output buffer, and flags the final word.
- Sits between a FIFO instance and any stream consumer (UART TX, packetiser, DMA sink).

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- LEN_WIDTH, 5, width of the burst length field (max burst 2^LEN_WIDTH-1).
- TIMEOUT_CYCLES, 64, starvation limit; used only with BURST_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock, all logic on posedge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  burst request, sampled in IDLE only
- len_i  in  LEN_WIDTH  burst length, captured with start_i
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle pulse when the burst completes
- err_o  out  1  sticky; set if rd_error_i is seen, cleared on an accepted start
- timeout_o  out  1  burst truncated by starvation; tied 0 without the macro
- rd_en_o  out  1  FIFO pop request
- rdata_i  in  WIDTH  FIFO read data, valid the cycle after a pop
- empty_i  in  1  FIFO empty flag
- rd_error_i  in  1  FIFO read-underflow error
- m_valid_o  out  1  stream data valid
- m_data_o  out  WIDTH  stream data
- m_last_o  out  1  marks the final word of a full-length burst
- m_ready_i  in  1  stream consumer ready

Behaviour:
Reset:
- All outputs 0.
- State returns to IDLE; remaining count, in-flight flag and buffer occupancy cleared.
- Reset asserted mid-burst aborts the burst: buffered words are discarded, no done_o.

State machine (IDLE, RUN, FLUSH):
- IDLE: on start_i, capture len_i into the remaining counter, clear err_o/timeout_o, go to RUN.
  - len_i == 0: go straight to FLUSH and pulse done_o next cycle.
- RUN: issue pops. Leave for FLUSH in the cycle the last pop is issued (remaining becomes 0).
- FLUSH: no pops. When buffer occupancy is 0 and nothing is in flight, pulse done_o for 1 cycle, go to IDLE, deassert busy_o that same cycle.
- start_i outside IDLE is ignored.

Pop rule:
- rd_en_o = (state == RUN) & ~empty_i & (remaining != 0) & (occ + inflight - (m_valid_o & m_ready_i) < 2).
- This path is combinational from m_ready_i. It sustains 1 word/cycle when the FIFO is non-empty and the consumer is always ready.
- rd_en_o must never be asserted while empty_i == 1.

Read latency:
- inflight is a register set by rd_en_o. The cycle after a pop, rdata_i is written into the 2-entry buffer.
- Push and pop of the buffer may occur in the same cycle.
- m_valid_o = (occ != 0). m_data_o = head entry.
- Minimum latency: start_i to first m_valid_o is 3 cycles (start -> RUN -> pop -> buffer).

Last flag:
- The buffer carries a last bit per entry, set on the word whose pop made remaining go 1 -> 0.
- m_last_o = head entry's last bit.

Stream rules:
- Once m_valid_o rises, m_data_o and m_last_o hold until m_ready_i.

Errors:
- rd_error_i sets err_o (sticky). Nothing is pushed into the buffer for that pop.

Optional Feature:
- Macro: BURST_TIMEOUT_EN.
- With the macro: a counter runs in RUN and increments each cycle rd_en_o is 0; it clears on any pop.
  - When it reaches TIMEOUT_CYCLES, go to FLUSH and set timeout_o (sticky until the next start).
  - Buffered words still drain. m_last_o is not asserted for a truncated burst. done_o still pulses.
- Without the macro: no counter exists, timeout_o is constant 0, and RUN waits indefinitely on an empty FIFO.

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/FLUSH), the default WIDTH shared with the FIFO, and the buffer depth constant (2).
- One sub-module: fifo_skid_buf, a 2-entry buffer of {last, data} with push/pop/occ. The FSM, counters and pop rule stay in the top module.

Test Plan:
- FIFO preloaded with 0x11..0x14, start with len=4, m_ready_i=1: four consecutive m_valid_o beats 0x11..0x14, m_last_o only on 0x14, done_o pulses 1 cycle after the last handshake, err_o=0.
- Same burst with m_ready_i toggling 1,0,0,1,...: no word lost or duplicated, order preserved, rd_en_o never pushes occupancy above 2.
- FIFO starts empty, start len=3, words written at cycles 10, 20, 30: rd_en_o stays low while empty_i=1, exactly 3 words out, done_o after the third.
- len=0: done_o pulses with no rd_en_o and no m_valid_o. A start_i pulse during busy_o is ignored (remaining count unchanged).
- Force rd_error_i=1 for one cycle mid-burst: err_o goes high and stays high until the next start.
- With BURST_TIMEOUT_EN and TIMEOUT_CYCLES=64: len=5 with only 2 words available; after 64 starved cycles timeout_o=1, the 2 words are delivered without m_last_o, then done_o. Assert rst_i mid-burst in a separate run: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// Constants shared by fifo_burst_reader and its skid buffer: FSM encoding,
// default data width (matches the FIFO) and output buffer depth.
package fifo_burst_reader_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int BUF_DEPTH     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry {last, data} buffer absorbing the FIFO's registered read latency.
// Same-cycle push and pop allowed; the caller never pushes into a full buffer.
module fifo_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             head_last_o,
  output logic [1:0]       occ_o
);

  localparam int PW = $clog2(BUF_DEPTH);

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t          mem_q [BUF_DEPTH];
  entry_t          mem_d [BUF_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]      occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = '{last: push_last_i, data: push_data_i};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    occ_d = occ_q + 2'(push_i) - 2'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head_data_o = mem_q[rd_ptr_q].data;
  assign head_last_o = mem_q[rd_ptr_q].last;
  assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops len_i words from a sync FIFO into a valid/ready stream, first beat 3 cycles after start;
// pops throttle on buffer space (combinational from m_ready_i). BURST_TIMEOUT_EN adds a starvation timeout.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int LEN_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 timeout_o,
  output logic                 rd_en_o,
  input  logic [WIDTH-1:0]     rdata_i,
  input  logic                 empty_i,
  input  logic                 rd_error_i,
  output logic                 m_valid_o,
  output logic [WIDTH-1:0]     m_data_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_last_q, inflight_last_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 err_q, err_d, to_q, to_d;
  logic [1:0]           occ;
  logic [2:0]           level, occ_next;
  logic                 buf_push, buf_pop, rd_en, starved;

  assign m_valid_o = (occ != 2'd0);
  assign buf_pop   = m_valid_o & m_ready_i;
  assign buf_push  = inflight_q & ~rd_error_i;
  assign level     = 3'(occ) + 3'(inflight_q) - 3'(buf_pop);
  assign occ_next  = 3'(occ) + 3'(buf_push) - 3'(buf_pop);
  assign rd_en     = (state_q == ST_RUN) & ~empty_i & (rem_q != '0) & (level < 3'(BUF_DEPTH));
  assign rd_en_o   = rd_en;

`ifdef BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = '0;
    starved    = 1'b0;
    if (state_q == ST_RUN && !rd_en) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
      starved    = (wait_cnt_d == TW'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`else
  assign starved = 1'b0;
  // TIMEOUT_CYCLES only shapes hardware when the timeout is compiled in.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    inflight_d      = rd_en;
    inflight_last_d = rd_en & (rem_q == LEN_WIDTH'(1));
    busy_d          = busy_q;
    done_d          = 1'b0;
    err_d           = err_q | rd_error_i;
    to_d            = to_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rem_d   = len_i;
          err_d   = 1'b0;
          to_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = (len_i == '0) ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (rd_en) rem_d = rem_q - 1'b1;
        if (rd_en && rem_q == LEN_WIDTH'(1)) begin
          state_d = ST_FLUSH;
        end else if (starved) begin
          state_d = ST_FLUSH;
          to_d    = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Finish on the edge that empties the buffer so done_o trails the last beat by one cycle.
        if (occ_next == 3'd0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      to_q            <= 1'b0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      to_q            <= to_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign timeout_o = to_q;

  fifo_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (buf_push),
    .push_data_i (rdata_i),
    .push_last_i (inflight_last_q),
    .pop_i       (buf_pop),
    .head_data_o (m_data_o),
    .head_last_o (m_last_o),
    .occ_o       (occ)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a queue-based FIFO model; define
// BURST_TIMEOUT_EN on both bench and RTL to exercise the starvation timeout.
`timescale 1ns/1ps
module tb_fifo_burst_reader;

  localparam int W  = 8;
  localparam int LW = 5;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [LW-1:0] len_i;
  logic          busy_o, done_o, err_o, timeout_o, rd_en_o;
  logic [W-1:0]  rdata_i;
  logic          empty_i;
  logic          rd_error_i;
  logic          m_valid_o;
  logic [W-1:0]  m_data_o;
  logic          m_last_o;
  logic          m_ready_i;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(W), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .timeout_o  (timeout_o),
    .rd_en_o    (rd_en_o),
    .rdata_i    (rdata_i),
    .empty_i    (empty_i),
    .rd_error_i (rd_error_i),
    .m_valid_o  (m_valid_o),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .m_ready_i  (m_ready_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] fifo_q[$];
  logic [W:0]   out_q[$];
  int cyc = 0;
  int n_pop, n_done, viol_empty, viol_hold, outst, max_out;
  int start_cyc, first_cyc, last_hs_cyc, done_cyc;
  bit first_seen, hold_pend;
  logic [W-1:0] hold_dat;
  logic hold_last;
  logic busy_at_done, err_at_done, to_at_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fifo_write(input logic [W-1:0] v);
    fifo_q.push_back(v);
    empty_i = 1'b0;
  endtask

  // Observe one cycle at the falling edge, then advance the FIFO model past the rising edge.
  task automatic cycle();
    bit do_pop;
    @(negedge clk);
    if (rd_en_o && empty_i) viol_empty++;
    if (rd_en_o) n_pop++;
    if (m_valid_o && !first_seen) begin
      first_seen = 1'b1;
      first_cyc  = cyc;
    end
    if (hold_pend && (m_valid_o !== 1'b1 || m_data_o !== hold_dat || m_last_o !== hold_last))
      viol_hold++;
    hold_pend = m_valid_o && !m_ready_i;
    hold_dat  = m_data_o;
    hold_last = m_last_o;
    outst = outst + int'(rd_en_o) - int'(m_valid_o && m_ready_i);
    if (outst > max_out) max_out = outst;
    if (m_valid_o && m_ready_i) begin
      out_q.push_back({m_last_o, m_data_o});
      last_hs_cyc = cyc;
    end
    if (done_o) begin
      n_done++;
      done_cyc     = cyc;
      busy_at_done = busy_o;
      err_at_done  = err_o;
      to_at_done   = timeout_o;
    end
    do_pop = rd_en_o;
    @(posedge clk);
    #1;
    if (do_pop && fifo_q.size() > 0) rdata_i = fifo_q.pop_front();
    empty_i = (fifo_q.size() == 0);
    cyc++;
  endtask

  // mode 0: ready high; mode 1: ready 1,0,0 repeating; mode 2: late writes, error pulse, stray start.
  task automatic run_burst(input int len, input int mode, input int budget);
    out_q.delete();
    n_pop = 0; n_done = 0; viol_empty = 0; viol_hold = 0; outst = 0; max_out = 0;
    first_seen = 1'b0; hold_pend = 1'b0; first_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    busy_at_done = 1'b1; err_at_done = 1'bx; to_at_done = 1'bx;
    start_i   = 1'b1;
    len_i     = LW'(len);
    start_cyc = cyc;
    cycle();
    start_i = 1'b0;
    for (int i = 0; i < budget && n_done == 0; i++) begin
      m_ready_i = (mode == 1) ? (i % 3 == 0) : 1'b1;
      if (mode == 2) begin
        if (i == 10 || i == 20 || i == 30) fifo_write(8'h30 + 8'(i / 10));
        rd_error_i = (i == 5);
        start_i    = (i == 15);
        if (i == 15) len_i = 5'd7;
      end
      cycle();
    end
    start_i    = 1'b0;
    rd_error_i = 1'b0;
    m_ready_i  = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic check_words(input string tag, input int base, input int n, input bit with_last);
    logic [W:0] exp;
    chk({tag, "_count"}, out_q.size(), n);
    for (int k = 0; k < n && k < out_q.size(); k++) begin
      exp = {(with_last && k == n - 1), 8'(base + k)};
      chk({tag, "_word"}, out_q[k], exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; len_i = '0; rdata_i = '0;
    empty_i = 1'b1; rd_error_i = 1'b0; m_ready_i = 1'b1;
    repeat (3) cycle();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_rd_en", rd_en_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_last", m_last_o, 0);
    rst_i = 1'b0;
    cycle();

    // Full-rate burst of four words.
    for (int k = 0; k < 4; k++) fifo_write(8'h11 + 8'(k));
    run_burst(4, 0, 40);
    check_words("b1", 'h11, 4, 1'b1);
    chk("b1_done_cnt", n_done, 1);
    chk("b1_done_after_last_hs", done_cyc - last_hs_cyc, 1);
    chk("b1_first_valid_latency", first_cyc - start_cyc, 3);
    chk("b1_busy_at_done", busy_at_done, 0);
    chk("b1_err", err_at_done, 0);
    chk("b1_timeout", to_at_done, 0);
    chk("b1_pops", n_pop, 4);

    // Consumer backpressure 1,0,0,...
    for (int k = 0; k < 4; k++) fifo_write(8'h21 + 8'(k));
    run_burst(4, 1, 80);
    check_words("b2", 'h21, 4, 1'b1);
    chk("b2_hold_violations", viol_hold, 0);
    chk("b2_occupancy_le_2", (max_out <= 2), 1);
    chk("b2_done_cnt", n_done, 1);

    // Starts empty, words trickle in; error pulse and stray start mid-burst.
    run_burst(3, 2, 200);
    check_words("b3", 'h31, 3, 1'b1);
    chk("b3_rd_en_while_empty", viol_empty, 0);
    chk("b3_pops", n_pop, 3);
    chk("b3_done_cnt", n_done, 1);
    chk("b3_err_at_done", err_at_done, 1);
    chk("b3_err_sticky", err_o, 1);

    // Zero-length burst; start also clears the sticky error.
    run_burst(0, 0, 20);
    chk("b4_pops", n_pop, 0);
    chk("b4_beats", out_q.size(), 0);
    chk("b4_done_cnt", n_done, 1);
    chk("b4_done_latency", done_cyc - start_cyc, 2);
    chk("b4_err_cleared", err_at_done, 0);

`ifdef BURST_TIMEOUT_EN
    // Only two of five words ever arrive.
    fifo_write(8'h51);
    fifo_write(8'h52);
    run_burst(5, 0, 300);
    check_words("b5", 'h51, 2, 1'b0);
    chk("b5_timeout_at_done", to_at_done, 1);
    chk("b5_done_cnt", n_done, 1);
    chk("b5_done_latency", done_cyc - start_cyc, 68);
    chk("b5_timeout_sticky", timeout_o, 1);
`endif

    // Reset in the middle of a stalled burst.
    for (int k = 0; k < 4; k++) fifo_write(8'h61 + 8'(k));
    m_ready_i = 1'b0;
    start_i   = 1'b1;
    len_i     = 5'd4;
    cycle();
    start_i = 1'b0;
    repeat (4) cycle();
    chk("mid_valid_before_rst", m_valid_o, 1);
    rst_i = 1'b1;
    cycle();
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_timeout", timeout_o, 0);
    chk("mid_rst_rd_en", rd_en_o, 0);
    chk("mid_rst_valid", m_valid_o, 0);
    chk("mid_rst_data", m_data_o, 0);
    chk("mid_rst_last", m_last_o, 0);
    rst_i     = 1'b0;
    m_ready_i = 1'b1;
    n_done    = 0;
    repeat (3) cycle();
    chk("mid_rst_no_done", n_done, 0);
    chk("mid_rst_no_valid", m_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
